cmp_hysteresis_monitor: RTL
===========================

// Module: cmp_hysteresis_monitor
// PURPOSE
//  Downstream consumer of magnitude_comparator_4bit (a_gt_b/a_lt_b/a_eq_b), typically comparing a sample (a)
//  against a threshold (b). It debounces the results into an alarm with set/clear hysteresis.
//  It also keeps saturating per-outcome event counters and flags any sample whose flags are not one-hot.
// PARAMETERS
//  SET_CNT  3  consecutive valid a_gt_b samples needed to raise alarm (>=1)
//  CLR_CNT  3  consecutive valid a_lt_b samples needed to drop alarm (>=1)
//  CNT_W    8  width of each outcome event counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  clr        in   1      synchronous clear; same effect as reset
//  in_valid   in   1      comparator flags valid this cycle
//  a_gt_b     in   1      comparator flag
//  a_lt_b     in   1      comparator flag
//  a_eq_b     in   1      comparator flag
//  alarm      out  1      debounced "above threshold" level
//  alarm_rise out  1      one-cycle pulse on alarm 0->1
//  err_flags  out  1      sticky: a non-one-hot flag set was accepted
//  state      out  2      FSM state (cmp_pkg::mon_state_e)
//  gt_cnt     out  CNT_W  accepted a_gt_b samples, saturating
//  lt_cnt     out  CNT_W  accepted a_lt_b samples, saturating
//  eq_cnt     out  CNT_W  accepted a_eq_b samples, saturating
// BEHAVIOUR
//  - Reset/clr: state=IDLE, run=0, alarm=0, alarm_rise=0, err_flags=0, all counters=0. clr wins over in_valid.
//  - Sample accepted on a clk edge with in_valid=1. in_valid=0: FSM, run and counters hold; alarm_rise=0.
//  - Every output is registered. An accepted sample is visible on the outputs one cycle later.
//  - Flags not exactly one-hot (000, 011, 111, ...): err_flags<=1. The sample is otherwise ignored:
//    no counter increment, no FSM move, run unchanged.
//  - Counters: +1 on the matching valid one-hot sample. They stick at 2^CNT_W-1 and do not wrap.
//  - FSM (run = consecutive-count register, width $clog2(max(SET_CNT,CLR_CNT)+1)):
//    IDLE:    gt -> run=1; SET_CNT==1 ? ALARM : PEND_SET. lt/eq -> stay, run=0.
//    PEND_SET: gt -> run+1; if run+1==SET_CNT -> ALARM, run=0. lt/eq -> IDLE, run=0.
//    ALARM:   lt -> run=1; CLR_CNT==1 ? IDLE : PEND_CLR. gt/eq -> stay.
//    PEND_CLR: lt -> run+1; if run+1==CLR_CNT -> IDLE, run=0. eq -> stay, run held (neutral band).
//             gt -> ALARM, run=0.
//  - alarm=1 exactly in ALARM and PEND_CLR.
//  - alarm_rise=1 only for the cycle in which alarm first reads 1 after being 0.
//  - Async reset mid-sequence discards any partial run. No alarm_rise is produced on reset release.
// STRUCTURE
//  - cmp_pkg: typedef enum logic[1:0] mon_state_e {IDLE=0, PEND_SET=1, ALARM=2, PEND_CLR=3};
//    typedef enum logic[1:0] cmp_res_e {RES_GT, RES_LT, RES_EQ, RES_BAD}; function decode_flags(gt,lt,eq)->cmp_res_e.
//  - Sub-module sat_counter #(W) (clk, rst_n, clr, inc, q), instantiated 3x for the outcome counters.
//  - Top holds the flag decode, the FSM, run and the alarm/alarm_rise/err_flags registers.
// TESTING (defaults SET_CNT=3, CLR_CNT=3, CNT_W=8; drive magnitude_comparator_4bit for stimulus)
//  1. Reset: rst_n=0 mid-cycle -> all outputs 0, state=IDLE immediately (async).
//  2. Set debounce: 3 valid samples a=10,b=5 -> state PEND_SET,PEND_SET,ALARM.
//     alarm=1 and alarm_rise=1 one cycle after the 3rd sample; alarm_rise=0 on the next cycle.
//  3. Glitch reject: gt,gt,lt,gt,gt -> alarm stays 0. gt_cnt=4, lt_cnt=1.
//  4. Hysteresis clear: from ALARM send lt,eq,lt,lt (a=3,b=8 / a=6,b=6) -> alarm held through eq.
//     alarm=0 after the 3rd lt (state IDLE). A gt inside PEND_CLR -> back to ALARM with no new alarm_rise.
//  5. Bad flags + in_valid=0: force gt=lt=1 with valid -> err_flags=1 sticky, counters and state unchanged.
//     gt samples with in_valid=0 -> no change.
//  6. Saturation/clr: 300 valid eq samples -> eq_cnt=255. clr=1 with in_valid=1 -> everything 0 next cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and helpers for the comparator hysteresis monitor.
//   mon_state_e  : monitor FSM state encoding (also exported on the state port)
//   cmp_res_e    : decoded comparator outcome
//   decode_flags : maps raw gt/lt/eq flags to a cmp_res_e; anything that is
//                  not exactly one-hot decodes to RES_BAD
// ---------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_SET = 2'd1,
        ALARM    = 2'd2,
        PEND_CLR = 2'd3
    } mon_state_e;

    // Plain constants with the same encoding, so the FSM register can be a
    // simple logic vector that legacy tools and checkers bind to easily.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PEND_SET = 2'd1;
    localparam logic [1:0] ST_ALARM    = 2'd2;
    localparam logic [1:0] ST_PEND_CLR = 2'd3;

    typedef enum logic [1:0] {
        RES_GT  = 2'd0,
        RES_LT  = 2'd1,
        RES_EQ  = 2'd2,
        RES_BAD = 2'd3
    } cmp_res_e;

    function automatic cmp_res_e decode_flags(input logic gt, input logic lt, input logic eq);
        cmp_res_e res;
        case ({gt, lt, eq})
            3'b100:  res = RES_GT;
            3'b010:  res = RES_LT;
            3'b001:  res = RES_EQ;
            default: res = RES_BAD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_hysteresis_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q -> 0)
//   clr   : synchronous clear (q -> 0), takes priority over inc
//   inc   : count enable
//   q     : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cmp_hysteresis_monitor.sv
// ---------------------------------------------------------------------------
// cmp_hysteresis_monitor
// Debounces magnitude-comparator results into an alarm level with separate
// set/clear run lengths, counts each outcome, and flags malformed flag sets.
//   clk, rst_n, clr           : clock, async active-low reset, sync clear
//   in_valid                  : comparator flags valid this cycle
//   a_gt_b, a_lt_b, a_eq_b    : comparator flags
//   alarm                     : debounced above-threshold level
//   alarm_rise                : one-cycle pulse when alarm goes 0->1
//   err_flags                 : sticky, set by an accepted non-one-hot flag set
//   state                     : FSM state (cmp_pkg::mon_state_e encoding)
//   gt_cnt, lt_cnt, eq_cnt    : saturating per-outcome sample counters
// Handshake: there is no back-pressure. A sample is consumed on every rising
// clk edge where in_valid=1; its effect appears on the outputs one cycle later.
// ---------------------------------------------------------------------------
module cmp_hysteresis_monitor
    import cmp_pkg::*;
#(
    parameter int SET_CNT = 3,
    parameter int CLR_CNT = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             err_flags,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);

    localparam int MAX_CNT = (SET_CNT > CLR_CNT) ? SET_CNT : CLR_CNT;
    localparam int RUN_W   = $clog2(MAX_CNT + 1);

    localparam logic [RUN_W-1:0] SET_RUN = RUN_W'(SET_CNT);
    localparam logic [RUN_W-1:0] CLR_RUN = RUN_W'(CLR_CNT);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    cmp_res_e         res;
    logic             take_gt;
    logic             take_lt;
    logic             take_eq;
    logic             take_bad;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [RUN_W-1:0] run_inc;
    logic             alarm_d;

    assign res      = decode_flags(a_gt_b, a_lt_b, a_eq_b);
    assign take_gt  = in_valid && (res == RES_GT);
    assign take_lt  = in_valid && (res == RES_LT);
    assign take_eq  = in_valid && (res == RES_EQ);
    assign take_bad = in_valid && (res == RES_BAD);
    assign run_inc  = run_q + RUN_ONE;

    // Next-state logic. Only well-formed accepted samples move the FSM; a
    // malformed or absent sample leaves state and run exactly as they were.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (take_gt || take_lt || take_eq) begin
            case (state_q)
                ST_IDLE: begin
                    if (take_gt) begin
                        run_d   = RUN_ONE;
                        state_d = (SET_CNT == 1) ? ST_ALARM : ST_PEND_SET;
                    end else begin
                        run_d = '0;
                    end
                end
                ST_PEND_SET: begin
                    if (take_gt) begin
                        if (run_inc == SET_RUN) begin
                            state_d = ST_ALARM;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end
                end
                ST_ALARM: begin
                    if (take_lt) begin
                        run_d   = RUN_ONE;
                        state_d = (CLR_CNT == 1) ? ST_IDLE : ST_PEND_CLR;
                    end
                end
                ST_PEND_CLR: begin
                    // eq is the neutral band: neither extends nor breaks the run.
                    if (take_lt) begin
                        if (run_inc == CLR_RUN) begin
                            state_d = ST_IDLE;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (take_gt) begin
                        state_d = ST_ALARM;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    assign alarm_d = (state_d == ST_ALARM) || (state_d == ST_PEND_CLR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            run_q      <= '0;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            err_flags  <= 1'b0;
        end else if (clr) begin
            state_q    <= ST_IDLE;
            run_q      <= '0;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            err_flags  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            alarm      <= alarm_d;
            // alarm_d equals alarm whenever nothing is accepted, so the pulse
            // is naturally suppressed on idle cycles and PEND_CLR -> ALARM.
            alarm_rise <= alarm_d && !alarm;
            if (take_bad) begin
                err_flags <= 1'b1;
            end
        end
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (take_gt),
        .q     (gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (take_lt),
        .q     (lt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (take_eq),
        .q     (eq_cnt)
    );

endmodule
